display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 15 +
 rtl/display_scan_tick.sv | 46 ++++
 rtl/display_scan.sv | 156 +++++++++++++++
 tb/tb_display_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and default constants for the display address scanner.
package display_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INTVL_DEF  = 200000000;
    localparam int CNT_W_DEF  = 32;

    // Scanner operating modes.
    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_PAUSE  = 2'd2
    } state_e;

endpackage

// File: rtl/display_scan_tick.sv
// Dwell counter: counts enabled cycles and emits a one-cycle tick on the
// terminal count INTVL-1, rolling back to zero on that same edge.
module scan_tick
    import display_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int INTVL = INTVL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(INTVL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal-count detect; only meaningful while counting.
    assign tick = enable && (count_q == TERM);

    // Next count: clear wins, then roll over at terminal count, else hold/increment.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == TERM) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Display address scanner: manual address pass-through, or an automatic scan
// over a latched [start, end] range with pause / single-step control.
module display_scan
    import display_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INTVL  = INTVL_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              display,
    input  logic [ADDR_W-1:0] sel_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              dir,
    input  logic              pause,
    input  logic              step,
    output logic [ADDR_W-1:0] real_addr,
    output logic              scanning,
    output logic              paused,
    output logic              wrap
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              dir_q, dir_d;
    logic              wrap_q, wrap_d;

    logic              cnt_en;
    logic              cnt_clr;
    logic              tick;
    logic              do_adv;
    logic [ADDR_W-1:0] adv_addr;
    logic              adv_wrap;

    scan_tick #(
        .CNT_W (CNT_W),
        .INTVL (INTVL)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (cnt_en),
        .clear  (cnt_clr),
        .tick   (tick)
    );

    // One-step advance within the latched range; reload from the far end at a range boundary.
    always_comb begin
        adv_wrap = 1'b0;
        adv_addr = addr_q;
        if (!dir_q) begin
            if (addr_q == end_q) begin
                adv_addr = start_q;
                adv_wrap = 1'b1;
            end else begin
                adv_addr = addr_q + ADDR_W'(1);
            end
        end else begin
            if (addr_q == start_q) begin
                adv_addr = end_q;
                adv_wrap = 1'b1;
            end else begin
                adv_addr = addr_q - ADDR_W'(1);
            end
        end
    end

    // Next-state, counter control and address selection; display=0 overrides everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start_d = start_q;
        end_d   = end_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        do_adv  = 1'b0;

        case (state_q)
            ST_MANUAL: begin
                addr_d  = sel_addr;
                cnt_clr = 1'b1;
                if (display) begin
                    state_d = ST_SCAN;
                    start_d = start_addr;
                    end_d   = end_addr;
                    dir_d   = dir;
                    addr_d  = dir ? end_addr : start_addr;
                end
            end
            ST_SCAN: begin
                cnt_en = 1'b1;
                do_adv = tick;
                if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (step) begin
                    do_adv  = 1'b1;
                    cnt_clr = 1'b1;
                end
                if (!pause) begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_MANUAL;
                addr_d  = sel_addr;
                cnt_clr = 1'b1;
            end
        endcase

        if (do_adv) begin
            addr_d = adv_addr;
            wrap_d = adv_wrap;
        end

        if ((state_q != ST_MANUAL) && !display) begin
            state_d = ST_MANUAL;
            addr_d  = sel_addr;
            wrap_d  = 1'b0;
            cnt_en  = 1'b0;
            cnt_clr = 1'b1;
        end
    end

    // State, address, latched range and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            end_q   <= end_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign real_addr = addr_q;
    assign scanning  = (state_q == ST_SCAN) || (state_q == ST_PAUSE);
    assign paused    = (state_q == ST_PAUSE);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a 4-cycle dwell.
module tb_display_scan;

    localparam int ADDR_W = 8;
    localparam int INTVL  = 4;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              display;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              dir;
    logic              pause;
    logic              step;
    logic [ADDR_W-1:0] real_addr;
    logic              scanning;
    logic              paused;
    logic              wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    display_scan #(
        .ADDR_W (ADDR_W),
        .INTVL  (INTVL),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .display    (display),
        .sel_addr   (sel_addr),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .dir        (dir),
        .pause      (pause),
        .step       (step),
        .real_addr  (real_addr),
        .scanning   (scanning),
        .paused     (paused),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] a, input logic sc,
                              input logic pa, input logic wr);
        check({tag, ".addr"},     32'(real_addr), 32'(a));
        check({tag, ".scanning"}, 32'(scanning),  32'(sc));
        check({tag, ".paused"},   32'(paused),    32'(pa));
        check({tag, ".wrap"},     32'(wrap),      32'(wr));
    endtask

    logic [7:0] asc_seq [4];
    logic [7:0] dsc_seq [5];

    initial begin
        asc_seq[0] = 8'h10; asc_seq[1] = 8'h11; asc_seq[2] = 8'h12; asc_seq[3] = 8'h10;
        dsc_seq[0] = 8'h01; dsc_seq[1] = 8'h00; dsc_seq[2] = 8'hFF; dsc_seq[3] = 8'hFE;
        dsc_seq[4] = 8'h01;

        rst_n      = 1'b0;
        display    = 1'b0;
        sel_addr   = 8'h00;
        start_addr = 8'h00;
        end_addr   = 8'h00;
        dir        = 1'b0;
        pause      = 1'b0;
        step       = 1'b0;

        #3;
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Manual pass-through with one-cycle latency.
        sel_addr = 8'h3C;
        tick();
        check_outs("manual", 8'h3C, 1'b0, 1'b0, 1'b0);

        // Ascending scan 0x10..0x12; range inputs change after entry and must be ignored.
        start_addr = 8'h10;
        end_addr   = 8'h12;
        dir        = 1'b0;
        display    = 1'b1;
        tick();
        check_outs("asc_entry", 8'h10, 1'b1, 1'b0, 1'b0);
        start_addr = 8'h55;
        end_addr   = 8'h66;
        dir        = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("asc_c%0d.addr", i), 32'(real_addr), 32'(asc_seq[i/4]));
            check($sformatf("asc_c%0d.wrap", i), 32'(wrap), 32'(i == 12));
        end

        // Dwell through 0x10 again, then pause on 0x11.
        repeat (4) tick();
        check("pre_pause.addr", 32'(real_addr), 32'h11);
        pause = 1'b1;
        tick();
        check_outs("pause_entry", 8'h11, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        check_outs("pause_hold", 8'h11, 1'b1, 1'b1, 1'b0);

        // Single steps while paused.
        step = 1'b1;
        tick();
        check_outs("step1", 8'h12, 1'b1, 1'b1, 1'b0);
        step = 1'b0;
        tick();
        check_outs("step1_hold", 8'h12, 1'b1, 1'b1, 1'b0);
        step = 1'b1;
        tick();
        check_outs("step2", 8'h10, 1'b1, 1'b1, 1'b1);
        step = 1'b0;
        tick();
        check_outs("step2_hold", 8'h10, 1'b1, 1'b1, 1'b0);

        // Resume: counter was cleared by the step, so a full dwell remains.
        pause = 1'b0;
        tick();
        check_outs("resume", 8'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("resume_c%0d.addr", i), 32'(real_addr), 32'h10);
        end
        tick();
        check("resume_adv.addr", 32'(real_addr), 32'h11);

        // display=0 while paused with a simultaneous step: manual wins, no advance.
        pause = 1'b1;
        tick();
        check_outs("pause2", 8'h11, 1'b1, 1'b1, 1'b0);
        display  = 1'b0;
        step     = 1'b1;
        sel_addr = 8'h77;
        tick();
        check_outs("exit_manual", 8'h77, 1'b0, 1'b0, 1'b0);
        step  = 1'b0;
        pause = 1'b0;

        // Descending scan through zero.
        start_addr = 8'hFE;
        end_addr   = 8'h01;
        dir        = 1'b1;
        display    = 1'b1;
        tick();
        check_outs("dsc_entry", 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("dsc_c%0d.addr", i), 32'(real_addr), 32'(dsc_seq[i/4]));
            check($sformatf("dsc_c%0d.wrap", i), 32'(wrap), 32'(i == 16));
        end

        // Asynchronous reset mid-dwell, checked between clock edges.
        tick();
        tick();
        display = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        sel_addr = 8'hA5;
        tick();
        check_outs("post_reset", 8'hA5, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
